// File: rtl/vga_tile_renderer.sv
// Tile-map VGA renderer: pixel-rate timing generator, two-stage pixel pipeline,
// one ROM row per tile row, and per-frame latched sprites drawn over the map.
module vga_tile_renderer #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter int          CLK_DIV  = 4,
    parameter int          TILE     = 20,
    parameter int          MAP_W    = 30,
    parameter int          MAP_H    = 21,
    parameter int          N_SPR    = 4,
    parameter bit          SYNC_NEG = 1'b1,
    parameter logic [11:0] BG_RGB   = 12'hF00,
    parameter logic [11:0] WALL_RGB = 12'hFF0,
    localparam int         AW       = (MAP_H > 1) ? $clog2(MAP_H) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [8*N_SPR-1:0]   spr_x,
    input  logic [8*N_SPR-1:0]   spr_y,
    input  logic [N_SPR-1:0]     spr_en,
    input  logic [12*N_SPR-1:0]  spr_rgb,
    output logic [AW-1:0]        map_addr,
    input  logic [MAP_W-1:0]     map_data,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic [11:0]          rgb,
    output logic [9:0]           h_count,
    output logic [9:0]           v_count,
    output logic                 frame_start
);

    localparam int CW = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam logic [9:0]  H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0]  H_ACT_W  = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT_W  = 10'(V_ACTIVE);
    localparam logic [9:0]  TILE_W   = 10'(TILE);
    localparam logic [9:0]  MAP_W_W  = 10'(MAP_W);
    localparam logic [9:0]  MAP_H_W  = 10'(MAP_H);
    localparam logic [19:0] TILE_20  = 20'(TILE);
    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic        SYNC_ON  = !SYNC_NEG;

    logic [3:0] div_cnt;
    logic       pix_tick;
    logic       h_end, v_end, frame_end;

    assign pix_tick  = (div_cnt == DIV_LAST);
    assign h_end     = (h_count == H_LAST);
    assign v_end     = (v_count == V_LAST);
    assign frame_end = pix_tick && h_end && v_end;

    // NOTE: every register here, shadow copies included, clears asynchronously so
    // a mid-frame reset restarts from a fully known state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt     <= '0;
            h_count     <= '0;
            v_count     <= '0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= pix_tick ? 4'd0 : div_cnt + 4'd1;
            frame_start <= frame_end;
            if (pix_tick) begin
                if (h_end) begin
                    h_count <= '0;
                    v_count <= v_end ? 10'd0 : v_count + 10'd1;
                end else begin
                    h_count <= h_count + 10'd1;
                end
            end
        end
    end

    // Sprite state is sampled once per frame so a frame never tears.
    logic [8*N_SPR-1:0]  spr_x_sh, spr_y_sh;
    logic [N_SPR-1:0]    spr_en_sh;
    logic [12*N_SPR-1:0] spr_rgb_sh;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spr_x_sh   <= '0;
            spr_y_sh   <= '0;
            spr_en_sh  <= '0;
            spr_rgb_sh <= '0;
        end else if (frame_end) begin
            spr_x_sh   <= spr_x;
            spr_y_sh   <= spr_y;
            spr_en_sh  <= spr_en;
            spr_rgb_sh <= spr_rgb;
        end
    end

    // Stage 1: coordinates, tile indices and the ROM row request.
    logic [9:0] s1_h, s1_v, s1_col, s1_row, row_now;
    assign row_now = v_count / TILE_W;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_h     <= '0;
            s1_v     <= '0;
            s1_col   <= '0;
            s1_row   <= '0;
            map_addr <= '0;
        end else if (pix_tick) begin
            s1_h     <= h_count;
            s1_v     <= v_count;
            s1_col   <= h_count / TILE_W;
            s1_row   <= row_now;
            map_addr <= (row_now >= MAP_H_W) ? AW'(MAP_H - 1) : AW'(row_now);
        end
    end

    // Stage 2 colour selection; the loop runs downward so the lowest index wins.
    logic        spr_hit, wall_hit, active;
    logic [11:0] spr_col, pix_rgb;
    logic [19:0] x0, y0, h20, v20;

    assign h20 = {10'd0, s1_h};
    assign v20 = {10'd0, s1_v};

    // NOTE: defaults come first so no path through the loop infers a latch.
    always_comb begin
        spr_hit = 1'b0;
        spr_col = '0;
        x0      = '0;
        y0      = '0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            x0 = 20'(spr_x_sh[8*i +: 8]) * TILE_20;
            y0 = 20'(spr_y_sh[8*i +: 8]) * TILE_20;
            if (spr_en_sh[i] && h20 >= x0 && h20 <= x0 + TILE_20 - 20'd1 &&
                v20 >= y0 && v20 <= y0 + TILE_20 - 20'd1) begin
                spr_hit = 1'b1;
                spr_col = spr_rgb_sh[12*i +: 12];
            end
        end
    end

    assign active   = (s1_h < H_ACT_W) && (s1_v < V_ACT_W);
    assign wall_hit = (s1_col < MAP_W_W) && (s1_row < MAP_H_W) && map_data[s1_col[CW-1:0]];
    assign pix_rgb  = !active ? 12'h000 : spr_hit ? spr_col : wall_hit ? WALL_RGB : BG_RGB;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb   <= '0;
            de    <= 1'b0;
            hsync <= !SYNC_ON;
            vsync <= !SYNC_ON;
        end else if (pix_tick) begin
            rgb   <= pix_rgb;
            de    <= active;
            hsync <= (s1_h >= HS_FIRST && s1_h <= HS_END) ? SYNC_ON : !SYNC_ON;
            vsync <= (s1_v >= VS_FIRST && s1_v <= VS_END) ? SYNC_ON : !SYNC_ON;
        end
    end

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Directed bench for vga_tile_renderer on a scaled-down 56x38 raster so that
// several whole frames fit in a short run.
module tb_vga_tile_renderer;

    localparam int CLK_DIV    = 4;
    localparam int N_SPR      = 2;
    localparam int FRAME_CLKS = 56 * 38 * CLK_DIV;

    logic                clk = 1'b0;
    logic                reset;
    logic [8*N_SPR-1:0]  spr_x, spr_y;
    logic [N_SPR-1:0]    spr_en;
    logic [12*N_SPR-1:0] spr_rgb;
    logic [2:0]          map_addr;
    logic [9:0]          map_data;
    logic                hsync, vsync, de, frame_start;
    logic [11:0]         rgb;
    logic [9:0]          h_count, v_count;

    logic [9:0] rom [8];

    vga_tile_renderer #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .CLK_DIV(CLK_DIV), .TILE(4), .MAP_W(10), .MAP_H(8), .N_SPR(N_SPR),
        .SYNC_NEG(1'b1), .BG_RGB(12'hF00), .WALL_RGB(12'hFF0)
    ) dut (
        .clk(clk), .reset(reset),
        .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .spr_rgb(spr_rgb),
        .map_addr(map_addr), .map_data(map_data),
        .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
        .h_count(h_count), .v_count(v_count), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) map_data <= rom[map_addr];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Counter history: hist2 is the counter value two pixel ticks back, i.e. the
    // pixel whose colour the outputs should be showing right now.
    logic [19:0] prev = 20'd0;
    logic [19:0] hist1 = '1;
    logic [19:0] hist2 = '1;
    int clk_idx = 0, fs_count = 0, fs_first = 0, fs_second = 0, fs_bad = 0;
    logic fs_last = 1'b0;

    task automatic step();
        @(negedge clk);
        clk_idx++;
        if ({h_count, v_count} != prev) begin
            hist2 = hist1;
            hist1 = prev;
            prev  = {h_count, v_count};
        end
        if (frame_start) begin
            fs_count++;
            if (fs_count == 1) fs_first = clk_idx;
            if (fs_count == 2) fs_second = clk_idx;
            if ({h_count, v_count} != 20'd0 || fs_last) fs_bad++;
        end
        fs_last = frame_start;
    endtask

    task automatic pix(input string tag, input int h, input int v,
                       input logic [11:0] exp_rgb, input logic exp_de);
        int n = 0;
        while (hist2 != {10'(h), 10'(v)} && n < 2 * FRAME_CLKS) begin
            step();
            n++;
        end
        if (n >= 2 * FRAME_CLKS) check({tag, "_timeout"}, 1, 0);
        check({tag, "_rgb"}, rgb, exp_rgb);
        check({tag, "_de"}, de, exp_de);
    endtask

    task automatic first_tick(input string tag);
        int n = 0;
        while (h_count == 10'd0 && n < 50) begin
            step();
            n++;
        end
        check({tag, "_clks"}, n, CLK_DIV);
        check({tag, "_h"}, h_count, 1);
        check({tag, "_v"}, v_count, 0);
    endtask

    int n_lo, n_hi, fs_before;

    initial begin
        reset   = 1'b0;
        spr_x   = {8'd2, 8'd2};
        spr_y   = {8'd3, 8'd3};
        spr_en  = 2'b11;
        spr_rgb = {12'h00F, 12'h0F0};
        for (int i = 0; i < 8; i++) rom[i] = 10'h000;
        rom[0] = 10'h001;
        rom[1] = 10'h200;
        rom[3] = 10'h004;

        repeat (3) step();
        check("rst_rgb", rgb, 12'h000);
        check("rst_de", de, 0);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_fs", frame_start, 0);
        check("rst_h", h_count, 0);
        check("rst_v", v_count, 0);
        reset = 1'b1;
        first_tick("start");

        // Frame 0: shadows still cleared, so only the map is visible.
        pix("f0_wall_0_0", 0, 0, 12'hFF0, 1);
        pix("f0_wall_3_0", 3, 0, 12'hFF0, 1);
        pix("f0_bg_4_0", 4, 0, 12'hF00, 1);
        pix("f0_bg_39_0", 39, 0, 12'hF00, 1);
        pix("f0_blank_40_0", 40, 0, 12'h000, 0);
        pix("f0_hs_43", 43, 0, 12'h000, 0);
        check("f0_hs_43_level", hsync, 1);
        pix("f0_hs_44", 44, 0, 12'h000, 0);
        check("f0_hs_44_level", hsync, 0);
        pix("f0_hs_49", 49, 0, 12'h000, 0);
        check("f0_hs_49_level", hsync, 0);
        pix("f0_hs_50", 50, 0, 12'h000, 0);
        check("f0_hs_50_level", hsync, 1);
        pix("f0_wall_36_5", 36, 5, 12'hFF0, 1);
        pix("f0_wall_8_12", 8, 12, 12'hFF0, 1);
        pix("f0_last_39_29", 39, 29, 12'hF00, 1);
        check("f0_last_hs", hsync, 1);
        check("f0_last_vs", vsync, 1);
        pix("f0_blank_20_30", 20, 30, 12'h000, 0);
        pix("f0_vs_55_31", 55, 31, 12'h000, 0);
        check("f0_vs_31_level", vsync, 1);
        pix("f0_vs_0_32", 0, 32, 12'h000, 0);
        check("f0_vs_32_level", vsync, 0);

        n_lo = 1;
        while (n_lo < 5000) begin
            step();
            if (vsync) break;
            n_lo++;
        end
        check("vsync_low_clks", n_lo, 2 * 56 * CLK_DIV);

        n_lo = 0;
        while (hsync && n_lo < 1000) begin step(); n_lo++; end
        n_lo = 0;
        while (!hsync && n_lo < 1000) begin step(); n_lo++; end
        n_hi = 0;
        while (hsync && n_hi < 1000) begin step(); n_hi++; end
        check("hsync_low_clks", n_lo, 6 * CLK_DIV);
        check("hsync_period_clks", n_lo + n_hi, 56 * CLK_DIV);

        // Frame 1: both sprites at tile (2,3); sprite 0 wins, even over the wall.
        pix("f1_mark_0_5", 0, 5, 12'hF00, 1);
        spr_x[7:0] = 8'd5;
        pix("f1_left_7_12", 7, 12, 12'hF00, 1);
        pix("f1_spr_8_12", 8, 12, 12'h0F0, 1);
        pix("f1_right_12_12", 12, 12, 12'hF00, 1);
        pix("f1_oldpos_20_12", 20, 12, 12'hF00, 1);
        pix("f1_spr_11_15", 11, 15, 12'h0F0, 1);
        pix("f1_below_8_16", 8, 16, 12'hF00, 1);

        // Frame 2: sprite 0 moved to column 5, sprite 1 now uncovered at (2,3).
        pix("f2_spr1_8_12", 8, 12, 12'h00F, 1);
        pix("f2_spr0_20_12", 20, 12, 12'h0F0, 1);
        pix("f2_mark_0_20", 0, 20, 12'hF00, 1);
        spr_x[15:8] = 8'd10;

        // Frame 3: sprite 1 off-screen, the wall shows through again.
        pix("f3_wall_8_12", 8, 12, 12'hFF0, 1);
        pix("f3_edge_39_12", 39, 12, 12'hF00, 1);
        pix("f3_spr0_23_15", 23, 15, 12'h0F0, 1);
        pix("f3_bg_24_15", 24, 15, 12'hF00, 1);
        pix("f3_bg_20_20", 20, 20, 12'hF00, 1);

        check("fs_period_clks", fs_second - fs_first, FRAME_CLKS);
        check("fs_count", fs_count, 3);
        check("fs_bad", fs_bad, 0);

        // Mid-line reset: outputs drop at once, timing restarts at (0,0).
        fs_before = fs_count;
        reset = 1'b0;
        #1;
        check("mid_rst_rgb", rgb, 12'h000);
        check("mid_rst_de", de, 0);
        check("mid_rst_hsync", hsync, 1);
        check("mid_rst_vsync", vsync, 1);
        check("mid_rst_h", h_count, 0);
        check("mid_rst_v", v_count, 0);
        repeat (3) step();
        reset = 1'b1;
        first_tick("restart");
        check("mid_rst_no_fs", fs_count, fs_before);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_tile_renderer.md
VGA_TILE_RENDERER -- requirements
Module: vga_tile_renderer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch, sync and back-porch pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch, sync and back-porch lines
- CLK_DIV, 4, clk cycles per pixel; legal range 2..16
- TILE, 20, tile edge in pixels
- MAP_W / MAP_H, 30 / 21, map size in tiles; one ROM word per row, MAP_W bits wide
- N_SPR, 4, sprite count; legal range 1..8
- SYNC_NEG, 1, 1 = sync pulses active-low
- BG_RGB / WALL_RGB, 12'hF00 / 12'hFF0, background and wall colours
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- clk, in, 1, single system clock
- reset, in, 1, asynchronous active-low reset
- spr_x, in, 8*N_SPR, sprite i tile column in bits [8i+7:8i]
- spr_y, in, 8*N_SPR, sprite i tile row
- spr_en, in, N_SPR, sprite i visible
- spr_rgb, in, 12*N_SPR, sprite i colour
- map_addr, out, clog2(MAP_H), map ROM row address
- map_data, in, MAP_W, ROM row word; valid one clk after map_addr
- hsync / vsync, out, 1, sync outputs
- de, out, 1, active-video flag aligned with rgb
- rgb, out, 12, pixel colour
- h_count / v_count, out, 10, raw (undelayed) beam counters
- frame_start, out, 1, one-clk pulse per frame

Function
REQ-003 pix_tick SHALL assert for one clk every CLK_DIV clks from a free-running divider; all pipeline registers and counters SHALL advance only on pix_tick.
REQ-004 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-005 h_count SHALL run 0..H_TOTAL-1 and wrap to 0; v_count SHALL increment on the h wrap, run 0..V_TOTAL-1 and wrap to 0.
REQ-006 The sync pulse SHALL be active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync SHALL use the same form on v; the active level is low when SYNC_NEG=1.
REQ-007 Stage 1 SHALL register h, v, tile column col = h/TILE and tile row row = v/TILE, and SHALL drive map_addr = row, saturated to MAP_H-1.
REQ-008 Stage 2 SHALL register rgb, de, hsync and vsync for the stage-1 coordinates; total latency from counter value to outputs SHALL be exactly 2 pix_ticks, and all four outputs SHALL be mutually aligned.
REQ-009 Colour priority SHALL be, highest first:
- outside the active area: rgb = 0, de = 0
- the lowest-index enabled sprite covering the pixel: its spr_rgb
- WALL_RGB when col < MAP_W, row < MAP_H and map_data[col] = 1
- otherwise BG_RGB
REQ-010 Sprite i SHALL cover h in [x*TILE, x*TILE+TILE-1] and v in [y*TILE, y*TILE+TILE-1], both bounds inclusive; products SHALL be computed at least 18 bits wide with no truncation.
REQ-011 spr_x, spr_y, spr_en and spr_rgb SHALL be captured into shadow registers only on the pix_tick where h = H_TOTAL-1 and v = V_TOTAL-1; changes at other times SHALL take effect only from the next frame.
REQ-012 frame_start SHALL pulse for one clk on the pix_tick where the counters wrap to (0,0).
REQ-013 A tile position off-screen (e.g. x*TILE >= H_ACTIVE) SHALL draw nothing and SHALL raise no error.

Reset
REQ-014 While reset = 0, asynchronously:
- divider, counters, pipeline and shadow registers SHALL clear to 0
- rgb = 0, de = 0, frame_start = 0
- hsync and vsync SHALL sit at their inactive level
REQ-015 The first pix_tick SHALL occur CLK_DIV clks after reset deasserts; reset asserted mid-frame SHALL restart timing at (0,0) with no partial pulse on any output.

Verification
REQ-016 Defaults, reset released -> hsync period 3200 clk with low time 384 clk; vsync period 1,680,000 clk with low time 2 lines; frame_start once per 1,680,000 clk.
REQ-017 map row 0 = 30'h1 -> in frame lines 0..19, rgb = 12'hFF0 for pixels 0..19 and 12'hF00 for pixels 20..639; de = 0 and rgb = 0 for pixels 640..799.
REQ-018 Sprite 0 at (2,3), sprite 1 at (2,3), both enabled -> pixels h 40..59, v 60..79 show spr_rgb[0] only; pixel h = 60 does not show the sprite.
REQ-019 spr_x[0] changed mid-frame -> the sprite position is unchanged until the frame after the next (0,0) wrap.
REQ-020 Counter at (639,479) -> rgb and de for that pixel appear exactly 2 pix_ticks later, aligned with hsync and vsync delayed by 2.
REQ-021 reset pulsed low for 3 clk mid-line -> outputs reach reset values immediately; h_count = 0 and v_count = 0 at the first pix_tick after release.
